// File: rtl/rotate_right_unit_pkg.sv
// Shared constants and types for the multi-cycle right shift/rotate unit.
package rotate_right_unit_pkg;

    localparam int WIDTH      = 16;                  // data width in bits
    localparam int LOG2_WIDTH = 4;                   // number of binary stages / amount bits used
    localparam int AMT_W      = 16;                  // width of the amount port
    localparam int STG_W      = $clog2(LOG2_WIDTH);  // stage index width

    // Operation modes; 2'b11 is reserved and executes as a rotate.
    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    // Index of the final stage, which writes the result instead of the work register.
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOG2_WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rotate_right_unit_shift_right_stage.sv
// One binary stage of the right shifter: moves data right by 2^idx_i when enabled.
// The vacated top bits are filled according to the mode (rotate, zero or sign).
module shift_right_stage
    import rotate_right_unit_pkg::*;
(
    input  logic [WIDTH-1:0] data_i,
    input  logic             enable_i,
    input  logic [STG_W-1:0] idx_i,
    input  logic [1:0]       mode_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0]      fill;
    logic [LOG2_WIDTH-1:0] sh;

    // Build a double-width word {fill, data}; shifting it right and keeping the low
    // half gives the rotated or filled result for any stage distance.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        case (mode_i)
            MODE_LSR: fill = '0;
            MODE_ASR: fill = {WIDTH{sign_i}};
            default:  fill = data_i;   // rotate, including the reserved encoding
        endcase
        sh         = '0;
        sh[idx_i]  = 1'b1;
        data_o     = data_i;
        if (enable_i) begin
            data_o = WIDTH'({fill, data_i} >> sh);
        end
    end

endmodule

// File: rtl/rotate_right_unit.sv
// Multi-cycle right rotate / logical shift / arithmetic shift unit.
// The amount is resolved one binary stage per clock (1, 2, 4, 8 bits), giving a fixed
// four-cycle latency from an accepted start to the done pulse.
module rotate_right_unit
    import rotate_right_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    state_t                state_q, state_d;
    logic [STG_W-1:0]      stg_q, stg_d;
    logic [WIDTH-1:0]      work_q, work_d;
    logic [LOG2_WIDTH-1:0] amt_q, amt_d;
    logic [1:0]            mode_q, mode_d;
    logic                  sign_q, sign_d;
    logic [WIDTH-1:0]      dout_q, dout_d;
    logic                  zero_q, zero_d;
    logic                  done_q, done_d;

    logic [WIDTH-1:0]      stage_data;
    logic                  stage_en;
    logic [STG_W-1:0]      stage_idx;
    logic [1:0]            stage_mode;
    logic                  stage_sign;
    logic [WIDTH-1:0]      stage_out;

    // Only the low amount bits matter (count modulo WIDTH); the rest are ignored on purpose.
    logic unused_amt_hi;
    assign unused_amt_hi = ^amount[AMT_W-1:LOG2_WIDTH];

    // Feed the single shared stage: fresh operands in IDLE, the work register while running.
    always_comb begin
        stage_data = work_q;
        stage_en   = amt_q[stg_q];
        stage_idx  = stg_q;
        stage_mode = mode_q;
        stage_sign = sign_q;
        if (state_q == ST_IDLE) begin
            stage_data = din;
            stage_en   = amount[0];
            stage_idx  = '0;
            stage_mode = mode;
            stage_sign = din[WIDTH-1];
        end
    end

    shift_right_stage u_stage (
        .data_i   (stage_data),
        .enable_i (stage_en),
        .idx_i    (stage_idx),
        .mode_i   (stage_mode),
        .sign_i   (stage_sign),
        .data_o   (stage_out)
    );

    // Next-state and datapath updates: capture on start, step stages, publish on the last one.
    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        work_d  = work_q;
        amt_d   = amt_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        dout_d  = dout_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = stage_out;
                    amt_d   = amount[LOG2_WIDTH-1:0];
                    mode_d  = mode;
                    sign_d  = din[WIDTH-1];
                    stg_d   = STG_W'(1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stg_q == STG_LAST) begin
                    dout_d  = stage_out;
                    zero_d  = (stage_out == '0);
                    done_d  = 1'b1;
                    stg_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    work_d = stage_out;
                    stg_d  = stg_q + STG_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset; an in-flight op is simply dropped.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stg_q   <= '0;
            work_q  <= '0;
            amt_q   <= '0;
            mode_q  <= MODE_ROR;
            sign_q  <= 1'b0;
            dout_q  <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
            dout_q  <= dout_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign dout = dout_q;
    assign zero = zero_q;
    assign done = done_q;
    assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_rotate_right_unit.sv
// Self-checking bench for rotate_right_unit: vector table, random ops against a bit-serial
// model, and hand-written sequences for busy-start, back-to-back and mid-operation reset.
module tb_rotate_right_unit;
    import rotate_right_unit_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] din;
    logic [AMT_W-1:0] amount;
    logic [1:0]       mode;
    logic [WIDTH-1:0] dout;
    logic             busy;
    logic             done;
    logic             zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] din;
        logic [15:0] amount;
        logic [1:0]  mode;
        logic [15:0] exp_dout;
        logic        exp_zero;
    } vec_t;

    typedef struct {
        logic [15:0] dout;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    rotate_right_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .din    (din),
        .amount (amount),
        .mode   (mode),
        .dout   (dout),
        .busy   (busy),
        .done   (done),
        .zero   (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial reference: one single-bit step per count.
    function automatic logic [15:0] ref_model(input logic [15:0] d, input logic [15:0] amt,
                                              input logic [1:0] m);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < int'(amt[3:0]); i++) begin
            case (m)
                2'b01:   r = {1'b0, r[15:1]};
                2'b10:   r = {d[15], r[15:1]};
                default: r = {r[0], r[15:1]};
            endcase
        end
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dout", {16'h0, dout}, {16'h0, e.dout});
                check("zero", {31'h0, zero}, {31'h0, e.zero});
            end
        end
    end

    // Drive a start for one cycle (caller is just after a falling edge) and queue the result.
    task automatic drive_start(input logic [15:0] d, input logic [15:0] a, input logic [1:0] m,
                               input logic [15:0] exp_d, input logic exp_z, input logic push);
        exp_t e;
        start  = 1'b1;
        din    = d;
        amount = a;
        mode   = m;
        if (push) begin
            e.dout = exp_d;
            e.zero = exp_z;
            sb.push_back(e);
        end
        @(negedge clk);
        start  = 1'b0;
        din    = 16'h0;
        amount = 16'h0;
        mode   = 2'b00;
    endtask

    // Bounded wait for done after the start cycle; checks busy each cycle and the latency.
    task automatic wait_done(input string tag);
        int n;
        n = 1;
        while (done !== 1'b1 && n < 8) begin
            check({tag, "_busy"}, {31'h0, busy}, 32'h1);
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic run_op(input logic [15:0] d, input logic [15:0] a, input logic [1:0] m,
                          input logic [15:0] exp_d, input logic exp_z, input string tag);
        drive_start(d, a, m, exp_d, exp_z, 1'b1);
        wait_done(tag);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        din    = 16'h0;
        amount = 16'h0;
        mode   = 2'b00;

        vecs[0]  = '{16'h0001, 16'h0001, MODE_ROR, 16'h8000, 1'b0};
        vecs[1]  = '{16'h1234, 16'h0014, MODE_ROR, 16'h4123, 1'b0};
        vecs[2]  = '{16'h1234, 16'h000C, MODE_ROR, 16'h2341, 1'b0};
        vecs[3]  = '{16'h8000, 16'h000F, MODE_ASR, 16'hFFFF, 1'b0};
        vecs[4]  = '{16'h8000, 16'h000F, MODE_LSR, 16'h0001, 1'b0};
        vecs[5]  = '{16'h8000, 16'h000F, 2'b11,    16'h0001, 1'b0};
        vecs[6]  = '{16'h00F0, 16'h0008, MODE_LSR, 16'h0000, 1'b1};
        vecs[7]  = '{16'hA5A5, 16'h0000, MODE_ROR, 16'hA5A5, 1'b0};
        vecs[8]  = '{16'h7FF0, 16'h0004, MODE_ASR, 16'h07FF, 1'b0};
        vecs[9]  = '{16'hFFFF, 16'hFFF3, MODE_LSR, 16'h1FFF, 1'b0};
        vecs[10] = '{16'h8001, 16'h0001, MODE_ASR, 16'hC000, 1'b0};
        vecs[11] = '{16'h0000, 16'h0005, MODE_ROR, 16'h0000, 1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_dout", {16'h0, dout}, 32'h0);
        check("rst_zero", {31'h0, zero}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'h0, busy}, 32'h0);

        // Table vectors, issued back-to-back in each done cycle.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].din, vecs[i].amount, vecs[i].mode,
                   vecs[i].exp_dout, vecs[i].exp_zero, $sformatf("vec%0d", i));
        end
        @(negedge clk);

        // Random operations against the bit-serial model.
        for (int i = 0; i < 20; i++) begin
            logic [15:0] d;
            logic [15:0] a;
            logic [1:0]  m;
            logic [15:0] r;
            d = 16'($urandom);
            a = 16'($urandom);
            m = 2'($urandom_range(0, 3));
            r = ref_model(d, a, m);
            run_op(d, a, m, r, (r == 16'h0), $sformatf("rnd%0d", i));
        end
        @(negedge clk);

        // Start while busy is ignored; start in the done cycle is accepted.
        drive_start(16'h1234, 16'h0004, MODE_ROR, 16'h4123, 1'b0, 1'b1);  // now T+1
        check("ign_busy1", {31'h0, busy}, 32'h1);
        @(negedge clk);                                                     // T+2
        check("ign_busy2", {31'h0, busy}, 32'h1);
        drive_start(16'hFFFF, 16'h0001, MODE_LSR, 16'h0000, 1'b0, 1'b0);  // now T+3
        check("ign_busy3", {31'h0, busy}, 32'h1);
        check("ign_nodone3", {31'h0, done}, 32'h0);
        @(negedge clk);                                                     // T+4
        check("ign_done4", {31'h0, done}, 32'h1);
        check("ign_busy4", {31'h0, busy}, 32'h0);
        drive_start(16'h00F0, 16'h0004, MODE_LSR, 16'h000F, 1'b0, 1'b1);  // accepted at T+4
        wait_done("b2b");                                                   // done at T+8
        @(negedge clk);
        check("b2b_done_clear", {31'h0, done}, 32'h0);

        // Reset during T+2 of an operation: it is discarded with no done pulse.
        drive_start(16'h1234, 16'h0004, MODE_ROR, 16'h0000, 1'b0, 1'b0);  // now T+1
        @(negedge clk);                                                     // T+2
        rst = 1'b1;
        @(negedge clk);                                                     // T+3
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_done", {31'h0, done}, 32'h0);
        check("mid_rst_dout", {16'h0, dout}, 32'h0);
        check("mid_rst_zero", {31'h0, zero}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_done", {31'h0, done}, 32'h0);
            check("post_rst_idle", {31'h0, busy}, 32'h0);
        end
        run_op(16'h0F00, 16'h0003, MODE_ASR, 16'h01E0, 1'b0, "after_rst");

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
